hazard_stim_checker: RTL
========================

Name: hazard_stim_checker

Overview:
- Drives the inputs of a hazard-prone combinational block, out = (~c & ~a) | (b & c), and watches its output.
- Walks all 8 input vectors in Gray-code order, so every step is a single-input change.
- After each step it waits a settle window, then compares the sampled output against the golden function.
- Counts two things: end-of-window mismatches, and static glitches seen on static (unchanged-expected) transitions.
- It is the driving and checking end for the team's hazard-demonstration circuits.

Parameters:
- SETTLE_CYCLES, 4, cycles held after each vector is applied before the check; legal range is 3 or more.
- CNT_W, 8, width of err_count and glitch_count; both counters saturate.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a run; sampled in IDLE or DONE only.
- dut_out  input  1  asynchronous output of the circuit under test.
- a  output  1  stimulus input a to the DUT (registered).
- b  output  1  stimulus input b to the DUT (registered).
- c  output  1  stimulus input c to the DUT (registered).
- busy  output  1  high from APPLY through the final CHECK.
- done  output  1  high while in DONE.
- pass  output  1  done & (err_count==0) & (glitch_count==0).
- err_count  output  CNT_W  number of end-of-window mismatches.
- glitch_count  output  CNT_W  number of static transitions on which a glitch was seen.
- step_idx  output  4  current step, 0..8.

Behaviour:
- Reset: state IDLE; a, b, c = 0; busy = done = pass = 0; counts = 0; step_idx = 0; synchroniser flops cleared.
- Reset has priority in every state. A reset mid-run aborts the run and returns all outputs to their reset values on the next edge.

Input synchroniser:
- dut_out passes through a 2-flop synchroniser; call the result s_out. Latency is 2 cycles.
- All checks use s_out only.

Vector sequence, as {a,b,c}, 9 steps:
- 000, 001, 011, 010, 110, 111, 101, 100, 000 (the last step is the wrap back to the start).
- Golden outputs, in step order: 1, 0, 1, 1, 0, 1, 0, 0, 1.
- Step k > 0 is "static" when golden(k) == golden(k-1). That gives k=3 (011->010, static-1) and k=7 (101->100, static-0).
- Step 0 is never static.

State machine:
- IDLE: on start go to APPLY. Clear both counters and set step_idx = 0.
- APPLY (1 cycle): register vector[step_idx] onto a, b, c. Set the glitch flag to 0. Go to SETTLE with the settle counter at 0.
- SETTLE (SETTLE_CYCLES cycles): on a static step, if s_out != golden(step_idx) in any cycle, set the glitch flag. Leave after SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - If s_out != golden(step_idx), increment err_count (saturating at 2^CNT_W - 1).
  - If the glitch flag is set, increment glitch_count (saturating).
  - If step_idx == 8, go to DONE; otherwise step_idx++ and go to APPLY.
- DONE: hold a, b, c, the counters and step_idx. start goes to APPLY with the counters cleared and step_idx = 0.

Timing and handshake rules:
- Each step takes SETTLE_CYCLES+2 cycles; a full run takes 9*(SETTLE_CYCLES+2) cycles from the first APPLY.
- start is ignored while busy.
- Non-static steps never count as glitches. Pulses shorter than one clock period may go undetected; this is documented as acceptable.
- A glitch and a mismatch on the same step increment both counters in the same CHECK cycle.

Test Plan:
- Ideal zero-delay golden DUT, start pulsed for 1 cycle, SETTLE_CYCLES=4 -> done rises 54 cycles after the first APPLY; err_count=0, glitch_count=0, pass=1; final abc=000.
- DUT output stuck at 0 -> err_count=5, glitch_count=1 (static-1 step 3 reads 0 throughout), pass=0.
- Golden DUT, but the bench forces dut_out=0 for 2 cycles beginning at APPLY+1 of step 3 (011->010) -> glitch_count=1, err_count=0, pass=0.
- Same forcing, but applied at step 4 (non-static) -> glitch_count=0, err_count=0, pass=1.
- CNT_W=2 with stuck-at-0 DUT -> err_count saturates at 3 and does not wrap.
- rst asserted mid-SETTLE of step 5 -> next edge: IDLE, abc=000, busy=0, counts=0. A start pulsed while busy, in a separate run, has no effect. A new start after reset gives the normal ideal-DUT result.

Source files
------------

// File: rtl/hazard_stim_checker_if.sv
// Stimulus and check bus between the hazard checker and its environment.
// The slave side is the checker; the master side owns start and the circuit output.
interface hazard_stim_checker_if #(parameter int CNT_W = 8);
  logic             start;
  logic             dut_out;
  logic             a, b, c;
  logic             busy, done, pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] glitch_count;
  logic [3:0]       step_idx;

  modport master (
    output start, dut_out,
    input  a, b, c, busy, done, pass, err_count, glitch_count, step_idx
  );
  modport slave (
    input  start, dut_out,
    output a, b, c, busy, done, pass, err_count, glitch_count, step_idx
  );
endinterface

// File: rtl/hazard_stim_checker.sv
// Walks the 8 Gray-code vectors of (~c & ~a) | (b & c), checks the synchronised
// output after each settle window and counts mismatches and static glitches.
module hazard_stim_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                 clk,
  input logic                 rst,
  hazard_stim_checker_if.slave bus
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Indexed by step 0..8; step 8 is the wrap back to 000.
  localparam logic [8:0] GOLDEN = 9'b100101101;
  localparam logic [8:0] STATIC = 9'b010001000;
  localparam logic [3:0] LAST   = 4'd8;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  logic [1:0]       sync_pipe;
  logic             s_out;
  logic [SW-1:0]    scnt;
  logic             gflag;
  logic [3:0]       step_q;
  logic [2:0]       abc_q;
  logic [CNT_W-1:0] err_q, glitch_q;
  logic [CNT_W-1:0] err_nxt, glitch_nxt;
  logic             busy_q, done_q, pass_q;
  logic             golden, mismatch;

  function automatic logic [2:0] vec_of(input logic [3:0] k);
    case (k)
      4'd0:    vec_of = 3'b000;
      4'd1:    vec_of = 3'b001;
      4'd2:    vec_of = 3'b011;
      4'd3:    vec_of = 3'b010;
      4'd4:    vec_of = 3'b110;
      4'd5:    vec_of = 3'b111;
      4'd6:    vec_of = 3'b101;
      4'd7:    vec_of = 3'b100;
      default: vec_of = 3'b000;
    endcase
  endfunction

  assign s_out    = sync_pipe[1];
  assign golden   = GOLDEN[step_q];
  assign mismatch = (s_out != golden);

  always_comb begin
    err_nxt    = err_q;
    glitch_nxt = glitch_q;
    if (mismatch && (err_q != CNT_MAX))   err_nxt    = err_q + CNT_W'(1);
    if (gflag && (glitch_q != CNT_MAX))   glitch_nxt = glitch_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync_pipe <= '0;
      scnt      <= '0;
      gflag     <= 1'b0;
      step_q    <= '0;
      abc_q     <= '0;
      err_q     <= '0;
      glitch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], bus.dut_out};
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= APPLY;
            err_q    <= '0;
            glitch_q <= '0;
            step_q   <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        APPLY: begin
          abc_q <= vec_of(step_q);
          gflag <= 1'b0;
          scnt  <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          // Early samples still carry the previous vector; on a static step
          // that value equals golden, so any deviation is a genuine glitch.
          if (STATIC[step_q] && mismatch) gflag <= 1'b1;
          if (scnt == SW'(SETTLE_CYCLES - 1)) state <= CHECK;
          else                                scnt  <= scnt + SW'(1);
        end
        CHECK: begin
          err_q    <= err_nxt;
          glitch_q <= glitch_nxt;
          if (step_q == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_nxt == '0) && (glitch_nxt == '0);
          end else begin
            step_q <= step_q + 4'd1;
            state  <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a            = abc_q[2];
  assign bus.b            = abc_q[1];
  assign bus.c            = abc_q[0];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.err_count    = err_q;
  assign bus.glitch_count = glitch_q;
  assign bus.step_idx     = step_q;
endmodule
